// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_flex
//  Description : Synchronous single-clock FIFO with full-depth capacity,
//                arbitrary depth (>= 2), standard or first-word-fall-through
//                read mode, fill level, programmable almost flags and
//                overflow/underflow error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_flex #(
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int FWFT         = 0,
   parameter int AFULL_LEVEL  = 12,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wr,
   input  logic                               rd,
   input  logic [DATA_WIDTH-1:0]              data_in,
   output logic [DATA_WIDTH-1:0]              data_out,
   output logic                               full,
   output logic                               empty,
   output logic                               almost_full,
   output logic                               almost_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int              C_PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              C_LW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [C_PW-1:0] C_PTR_LAST = C_PW'(FIFO_DEPTH - 1);
   localparam logic [C_LW-1:0] C_DEPTH    = C_LW'(FIFO_DEPTH);
   localparam logic [C_LW-1:0] C_AFULL    = C_LW'(AFULL_LEVEL);
   localparam logic [C_LW-1:0] C_AEMPTY   = C_LW'(AEMPTY_LEVEL);

   // Storage is never reset; the pointers alone define which words are live.
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_LW-1:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;

   logic w_empty;
   logic w_full;
   logic w_rd_ok;
   logic w_wr_ok;

   // Status flags are decoded from the registered count only.
   always_comb begin
      w_empty      = (count_q == '0);
      w_full       = (count_q == C_DEPTH);
      empty        = w_empty;
      full         = w_full;
      almost_full  = (count_q >= C_AFULL);
      almost_empty = (count_q <= C_AEMPTY);
      level        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // Accept decisions: a write into a full FIFO is allowed when a read frees a slot.
   always_comb begin
      w_rd_ok = rd && !w_empty;
      w_wr_ok = wr && (!w_full || w_rd_ok);
   end

   // Next-state: pointers wrap by explicit compare, level tracks net change.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = wr && !w_wr_ok;
      underflow_d = rd && !w_rd_ok;
      if (w_wr_ok) begin
         wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_rd_ok) begin
         rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (w_wr_ok && !w_rd_ok) begin
         count_d = count_q + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage write; suppressed during reset so a reset cycle has no side effects.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; forced to zero while nothing is stored.
         always_comb begin
            data_out = w_empty ? '0 : mem_q[rd_ptr_q];
         end
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q, dout_d;

         // Registered read: capture the head word on an accepted read, else hold.
         always_comb begin
            dout_d = dout_q;
            if (w_rd_ok) begin
               dout_d = mem_q[rd_ptr_q];
            end
         end

         // Read data register, cleared by reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q <= '0;
            end else begin
               dout_q <= dout_d;
            end
         end

         assign data_out = dout_q;
      end
   endgenerate

endmodule
`default_nettype wire
